// File: rtl/uart_mem_responder.sv
// Byte-level command responder: decodes ping / memory read / memory write commands arriving
// from a UART receiver, drives a single-port memory and returns one reply byte per command.
module uart_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  input  logic              tx_empty_i,
  output logic              tx_ld_o,
  output logic [7:0]        tx_byte_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o,
  output logic              overrun_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StGetAddr, StGetData, StMemWr, StMemRd, StRdWait, StSend
  } state_e;

  state_e            state_q, state_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        reply_q, reply_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cmd_err_q, cmd_err_d;
  logic              overrun_q, overrun_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      reply_q    <= '0;
      cnt_q      <= '0;
      cmd_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      reply_q    <= reply_d;
      cnt_q      <= cnt_d;
      cmd_err_q  <= cmd_err_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    reply_d    = reply_q;
    cnt_d      = '0;
    cmd_err_d  = cmd_err_q;
    overrun_d  = overrun_q;
    tx_ld_o    = 1'b0;
    mem_we_o   = 1'b0;
    mem_re_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          unique case (rx_byte_i)
            8'h50: begin
              reply_d = 8'h50;
              state_d = StSend;
            end
            8'h52: begin
              is_write_d = 1'b0;
              state_d    = StGetAddr;
            end
            8'h57: begin
              is_write_d = 1'b1;
              state_d    = StGetAddr;
            end
            default: begin
              reply_d   = 8'h3F;
              cmd_err_d = 1'b1;
              state_d   = StSend;
            end
          endcase
        end
      end
      StGetAddr, StGetData: begin
        // An arriving byte wins over a simultaneous timeout expiry.
        if (rx_valid_i) begin
          if (state_q == StGetAddr) begin
            addr_d  = ADDR_W'(rx_byte_i);
            state_d = is_write_q ? StGetData : StMemRd;
          end else begin
            data_d  = rx_byte_i;
            state_d = StMemWr;
          end
        end else if (cnt_q == CntLast) begin
          cmd_err_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StMemWr: begin
        mem_we_o = 1'b1;
        reply_d  = 8'h4B;
        state_d  = StSend;
      end
      StMemRd: begin
        mem_re_o = 1'b1;
        state_d  = StRdWait;
      end
      StRdWait: begin
        reply_d = mem_rdata_i;
        state_d = StSend;
      end
      StSend: begin
        if (tx_empty_i) begin
          tx_ld_o = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rx_valid_i && (state_q inside {StMemWr, StMemRd, StRdWait, StSend})) begin
      overrun_d = 1'b1;
    end
  end

  assign tx_byte_o   = reply_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = data_q;
  assign busy_o      = (state_q != StIdle);
  assign cmd_err_o   = cmd_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_mem_responder.sv
// Directed bench for uart_mem_responder: ping, write/read, unknown opcode, timeout,
// back-pressure with overrun, and reset in the middle of a write command.
module tb_uart_mem_responder;

  logic       clk;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_empty;
  logic       tx_ld;
  logic [7:0] tx_byte;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       cmd_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  int         tx_cnt  = 0;
  int         tx_viol = 0;
  int         we_cnt  = 0;
  int         re_cnt  = 0;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] mem [256];

  uart_mem_responder #(
    .ADDR_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rx_valid_i  (rx_valid),
    .rx_byte_i   (rx_byte),
    .tx_empty_i  (tx_empty),
    .tx_ld_o     (tx_ld),
    .tx_byte_o   (tx_byte),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_re_o    (mem_re),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .cmd_err_o   (cmd_err),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Mid-cycle observer of strobes and transmit loads.
  always @(negedge clk) begin
    if (tx_ld) begin
      tx_cnt  = tx_cnt + 1;
      tx_last = tx_byte;
      if (!tx_empty) tx_viol = tx_viol + 1;
    end
    if (mem_we) we_cnt = we_cnt + 1;
    if (mem_re) re_cnt = re_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte is accepted at the next edge; returns #1 into the following cycle.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    reset = 1'b1;
    step();
    step();
    outs = {tx_ld, tx_byte, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err, overrun};
    total++;
    if (outs !== 30'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ping();
    int base;
    base = tx_cnt;
    send(8'h50);
    total++;
    if (tx_ld !== 1'b1 || tx_byte !== 8'h50) begin
      bad++;
      $display("FAIL ping_reply got=%b/%h exp=1/50", tx_ld, tx_byte);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL ping_busy got=%b exp=1", busy);
    end
    step();
    total++;
    if (busy !== 1'b0 || tx_cnt - base != 1) begin
      bad++;
      $display("FAIL ping_done busy=%b loads=%0d exp busy=0 loads=1", busy, tx_cnt - base);
    end
  endtask

  task automatic test_write_read();
    int bw;
    int br;
    bw = we_cnt;
    br = re_cnt;
    send(8'h57);
    send(8'h10);
    total++;
    if (busy !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL wr_wait_data busy=%b we=%b exp busy=1 we=0", busy, mem_we);
    end
    send(8'hA5);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin
      bad++;
      $display("FAIL wr_strobe got=%b/%h/%h exp=1/10/a5", mem_we, mem_addr, mem_wdata);
    end
    step();
    total++;
    if (tx_ld !== 1'b1 || tx_byte !== 8'h4B) begin
      bad++;
      $display("FAIL wr_reply got=%b/%h exp=1/4b", tx_ld, tx_byte);
    end
    step();
    send(8'h52);
    send(8'h10);
    total++;
    if (mem_re !== 1'b1 || mem_addr !== 8'h10) begin
      bad++;
      $display("FAIL rd_strobe got=%b/%h exp=1/10", mem_re, mem_addr);
    end
    step();
    total++;
    if (tx_ld !== 1'b0 || mem_re !== 1'b0) begin
      bad++;
      $display("FAIL rd_wait got ld=%b re=%b exp ld=0 re=0", tx_ld, mem_re);
    end
    step();
    total++;
    if (tx_ld !== 1'b1 || tx_byte !== 8'hA5) begin
      bad++;
      $display("FAIL rd_reply got=%b/%h exp=1/a5", tx_ld, tx_byte);
    end
    step();
    total++;
    if (we_cnt - bw != 1 || re_cnt - br != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wr_rd_counts got we=%0d re=%0d busy=%b exp 1/1/0",
               we_cnt - bw, re_cnt - br, busy);
    end
  endtask

  task automatic test_unknown();
    pulse_reset();
    total++;
    if (cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL unk_pre_err got=%b exp=0", cmd_err);
    end
    send(8'h00);
    total++;
    if (tx_ld !== 1'b1 || tx_byte !== 8'h3F) begin
      bad++;
      $display("FAIL unk_reply got=%b/%h exp=1/3f", tx_ld, tx_byte);
    end
    total++;
    if (cmd_err !== 1'b1) begin
      bad++;
      $display("FAIL unk_err got=%b exp=1", cmd_err);
    end
    step();
    send(8'h50);
    total++;
    if (tx_ld !== 1'b1 || tx_byte !== 8'h50 || cmd_err !== 1'b1) begin
      bad++;
      $display("FAIL unk_then_ping got=%b/%h err=%b exp=1/50 err=1", tx_ld, tx_byte, cmd_err);
    end
    step();
  endtask

  task automatic test_timeout();
    int bt;
    int br;
    pulse_reset();
    bt = tx_cnt;
    br = re_cnt;
    send(8'h52);
    repeat (15) step();
    total++;
    if (busy !== 1'b1 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL to_early busy=%b err=%b exp busy=1 err=0", busy, cmd_err);
    end
    step();
    total++;
    if (busy !== 1'b0 || cmd_err !== 1'b1) begin
      bad++;
      $display("FAIL to_expire busy=%b err=%b exp busy=0 err=1", busy, cmd_err);
    end
    step();
    total++;
    if (tx_cnt != bt || re_cnt != br) begin
      bad++;
      $display("FAIL to_no_activity loads=%0d reads=%0d exp 0/0", tx_cnt - bt, re_cnt - br);
    end
  endtask

  task automatic test_overrun();
    int bt;
    pulse_reset();
    bt = tx_cnt;
    tx_empty = 1'b0;
    send(8'h50);
    total++;
    if (tx_ld !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ov_hold got ld=%b busy=%b exp ld=0 busy=1", tx_ld, busy);
    end
    send(8'h50);
    step();
    step();
    total++;
    if (overrun !== 1'b1 || busy !== 1'b1 || tx_cnt != bt) begin
      bad++;
      $display("FAIL ov_flag ov=%b busy=%b loads=%0d exp 1/1/0", overrun, busy, tx_cnt - bt);
    end
    tx_empty = 1'b1;
    step();
    step();
    step();
    total++;
    if (tx_cnt - bt != 1 || tx_last !== 8'h50 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ov_release loads=%0d byte=%h busy=%b exp 1/50/0",
               tx_cnt - bt, tx_last, busy);
    end
    total++;
    if (tx_viol != 0 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL ov_sticky viol=%0d ov=%b exp 0/1", tx_viol, overrun);
    end
  endtask

  task automatic test_reset_mid_write();
    int bw;
    logic [29:0] outs;
    bw = we_cnt;
    send(8'h57);
    send(8'h20);
    reset = 1'b1;
    step();
    outs = {tx_ld, tx_byte, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err, overrun};
    total++;
    if (outs !== 30'h0) begin
      bad++;
      $display("FAIL midrst_outputs got=%h exp=0", outs);
    end
    reset = 1'b0;
    step();
    step();
    total++;
    if (we_cnt != bw || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_no_write writes=%0d busy=%b exp 0/0", we_cnt - bw, busy);
    end
    send(8'h50);
    total++;
    if (tx_ld !== 1'b1 || tx_byte !== 8'h50) begin
      bad++;
      $display("FAIL midrst_ping got=%b/%h exp=1/50", tx_ld, tx_byte);
    end
    step();
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tx_empty = 1'b1;
    test_reset();
    test_ping();
    test_write_read();
    test_unknown();
    test_timeout();
    test_overrun();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_mem_responder.md
# uart_mem_responder

Byte-level command responder on the user side of the UART. It consumes received bytes, decodes a small command set (ping, memory read, memory write), drives a single-port memory and returns one reply byte per command through the UART transmit load handshake. It lets a host on the serial line inspect and modify on-chip memory with no CPU involvement.

## Interface
- ADDR_W, 8: memory address width; fixed at 8 for this protocol (one address byte).
- TIMEOUT, 100000: idle cycles allowed between bytes of one command before it is abandoned.
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: rx_byte holds a newly received byte.
- rx_byte  in  8  received byte; sampled only when rx_valid=1.
- tx_empty  in  1  transmitter idle; must fall the cycle after tx_ld and stay low until the byte is sent.
- tx_ld  out  1  one-cycle pulse loading tx_byte into the transmitter.
- tx_byte  out  8  reply byte; stable while tx_ld=1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  write data.
- mem_we  out  1  write strobe, one cycle.
- mem_re  out  1  read strobe, one cycle.
- mem_rdata  in  8  read data, valid the cycle after mem_re.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  sticky: unknown opcode or timeout occurred.
- overrun  out  1  sticky: byte arrived while it could not be accepted.

## Operation
- Commands: 0x50 'P' -> reply 0x50. 0x52 'R', addr -> reply mem[addr]. 0x57 'W', addr, data -> mem[addr]=data, reply 0x4B 'K'. Any other opcode -> reply 0x3F '?', set cmd_err.
- States: IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, SEND.
- IDLE + rx_valid: 'P' -> SEND (reply 0x50); 'R'/'W' -> GET_ADDR, latch opcode; other -> SEND (reply 0x3F).
- GET_ADDR + rx_valid: latch addr; opcode R -> MEM_RD, W -> GET_DATA.
- GET_DATA + rx_valid: latch data -> MEM_WR.
- MEM_WR: mem_we=1 for one cycle with mem_addr/mem_wdata -> SEND (reply 0x4B).
- MEM_RD: mem_re=1 for one cycle -> RD_WAIT. RD_WAIT: capture mem_rdata as reply -> SEND.
- SEND: wait until tx_empty=1; then tx_ld=1 one cycle with tx_byte=reply -> IDLE.
- Bytes accepted only in IDLE, GET_ADDR, GET_DATA. rx_valid in MEM_WR, MEM_RD, RD_WAIT, SEND: byte dropped, overrun set, state unaffected.
- Timeout counter: cleared on every accepted byte and in IDLE; counts in GET_ADDR/GET_DATA; on reaching TIMEOUT -> IDLE, cmd_err set, no reply sent. Width $clog2(TIMEOUT+1), no wrap.
- rx_valid on the same cycle as timeout expiry: byte accepted, timeout ignored.
- cmd_err and overrun cleared only by reset.

## Timing
- Reset (any state, mid-command included): next edge state=IDLE; tx_ld, tx_byte, mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err, overrun all 0; pending reply discarded, no partial memory write.
- Address byte for 'R' accepted at edge T: mem_re=1 in cycle T+1, rdata captured at T+2, tx_ld=1 in cycle T+3 if tx_empty=1.
- Data byte for 'W' accepted at T: mem_we=1 in cycle T+1, tx_ld earliest in cycle T+2.
- 'P' or unknown opcode accepted at T: tx_ld earliest in cycle T+1.
- tx_ld never asserted while tx_empty=0; never two tx_ld pulses within 2 cycles.
- busy=1 from the cycle after an opcode is accepted until the cycle after tx_ld (or timeout).

## Test plan
- Ping: rx 0x50, tx_empty=1 -> single tx_ld with tx_byte=0x50 one cycle later; busy returns low.
- Write/read: rx 0x57,0x10,0xA5 -> mem_we with addr 0x10, data 0xA5, reply 0x4B; then rx 0x52,0x10 -> mem_re addr 0x10, reply 0xA5 at T+3.
- Unknown opcode 0x00 -> reply 0x3F, cmd_err=1; subsequent ping still answered 0x50.
- Timeout: TIMEOUT=16, rx 0x52 then silence 16 cycles -> back to IDLE, cmd_err=1, no tx_ld, no mem_re.
- Back-pressure/overrun: hold tx_empty=0, rx 0x50 then 0x50 while in SEND -> second byte dropped, overrun=1; release tx_empty -> exactly one tx_ld 0x50.
- Reset mid-write: rx 0x57,0x20, assert reset before data byte -> all outputs 0, no mem_we; fresh 0x50 answered normally.
